serial_addsub: RTL and testbench
================================

# serial_addsub

Byte-serial (digit-serial) modular adder/subtractor for the serialized SEED datapath, generalised from the single-digit borrow subtractor. It consumes NUM_DIGITS digits of two operands LSB-first, one digit per accepted cycle. A carry or borrow is kept in a register between digits, so one instance computes full-word results such as the 32-bit key-schedule terms A+C−KC and B−D+KC without a wide adder. It sits between the key-schedule controller and the G-function input registers. Add/subtract mode and the initial carry/borrow are selected per operation.

## Interface
- DIGIT_W, 8, digit width in bits (≥1)
- NUM_DIGITS, 4, digits per operand (≥1); word width = DIGIT_W·NUM_DIGITS
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a new operation; implies in_valid; digit 0 presented on a_in/b_in
- mode  in  1  sampled with start: 0 = add, 1 = subtract (a − b)
- cin  in  1  sampled with start: initial carry (add) or borrow (sub); 0 for plain modular ops
- in_valid  in  1  digit pair on a_in/b_in valid this cycle
- a_in  in  DIGIT_W  operand A digit, LSB digit first
- b_in  in  DIGIT_W  operand B digit, LSB digit first
- res  out  DIGIT_W  registered result digit
- res_valid  out  1  res valid this cycle
- res_last  out  1  res is the final (MSB) digit
- cout  out  1  final carry (add) or borrow (sub); valid only with res_last
- busy  out  1  operation in progress; more digits expected

## Operation
- FSM states:
  - IDLE: accepts start only; in_valid without start is ignored.
  - RUN: accepts in_valid digits.
- Accept condition: start, or (RUN and in_valid).
- Arithmetic per accepted digit, with c = cin on the start digit, else the stored carry/borrow register:
  - Add: {c_next, d} = a_in + b_in + c.
  - Sub: {c_next, d} = {1'b0,a_in} − {1'b0,b_in} − c; c_next is bit DIGIT_W of the (DIGIT_W+1)-bit difference (1 = borrow).
  - The result is modular in 2^(DIGIT_W·NUM_DIGITS).
- Digit counter: cleared by start, incremented on each accept.
  - The digit accepted with counter = NUM_DIGITS−1 is the last digit: it sets res_last, loads cout from c_next and returns the FSM to IDLE.
  - NUM_DIGITS = 1: the start digit is the last digit; the FSM stays in IDLE.
- Registers updated on every accept: res ← d, res_valid ← 1, res_last ← (last digit), carry register ← c_next. In any cycle without an accept, res_valid ← 0 and res_last ← 0.
- cout: loaded only with the last digit; otherwise holds its value.
- Mode: latched at start and held for the whole operation. A mode change while busy has no effect.
- start while busy: aborts the current operation and restarts it with the new mode, cin and digit 0. No res_last is produced for the aborted operation.
- Stalls: in_valid low in RUN holds the counter, carry and mode. res_valid is 0 during the stall.
- busy = (state == RUN).

## Timing
- Reset values: res=0, res_valid=0, res_last=0, cout=0, busy=0, state IDLE, counter 0, carry 0.
- Latency: result digit k appears one cycle after digit k is accepted.
- Throughput: one digit per cycle.
- A full operation takes NUM_DIGITS accepted cycles. The last result digit appears NUM_DIGITS cycles after start when there are no stalls.
- Back-to-back operations: start may be asserted in the cycle directly after the last digit is accepted. No bubble is required.
- Reset asserted mid-operation: all state clears immediately, and any partial result is discarded.

## Structure
- Shared package seed_pkg holds:
  - MODE_ADD = 1'b0 and MODE_SUB = 1'b1
  - the FSM state enum {IDLE, RUN}
- Counter width: $clog2(NUM_DIGITS), minimum 1 bit.
- Sub-module digit_addsub (parameter DIGIT_W) is purely combinational:
  - inputs: a, b, c, mode
  - outputs: d, c_next
- serial_addsub owns the FSM, counter, carry register and output registers.

## Test plan
- Sub, DIGIT_W=8, NUM_DIGITS=4, cin=0: A=0x12345678, B=0x9E3779B9 (KC0) → res digits BF, DC, FC, 73 on consecutive cycles; res_last with 73; cout=1.
- Add, cin=0: 0xFFFFFFFF + 0x00000001 → 00, 00, 00, 00; cout=1. Repeat as sub: 0x00000000 − 0x00000001 → FF, FF, FF, FF; cout=1 (borrow).
- Stall: same KC0 subtraction with in_valid low for 2 cycles after digit 1 → identical digits and cout; res_valid low during the stall; busy high throughout.
- Back-to-back: add of 0x00000001 + 0x00000001, immediately followed by sub of 0x00000005 − 0x00000003 with cin=1 → digits 02,00,00,00 (cout=0), then 01,00,00,00 (cout=0), with no idle cycle between operations.
- Restart: start an add, then assert start with mode=sub after 2 digits → no res_last for the first operation; the second operation completes correctly.
- Reset: rst_n low mid-operation → all outputs 0 asynchronously; after release, a fresh start runs normally. Also cover NUM_DIGITS=1: one-cycle operation with res_last and cout on the first result.

Source files
------------

// File: rtl/seed_pkg.sv
// seed_pkg: shared mode encodings and FSM state type for the serialized SEED datapath
package seed_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/digit_addsub.sv
// digit_addsub: one-digit adder/subtractor with carry/borrow in and out
module digit_addsub
  import seed_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               c,
  input  logic               mode,
  output logic [DIGIT_W-1:0] d,
  output logic               c_next
);
  logic [DIGIT_W:0] sum;
  // Extra top bit is the carry out on add and the borrow out on subtract
  always_comb begin
    sum = (mode == MODE_SUB) ? {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, c}
                             : {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, c};
  end
  assign d      = sum[DIGIT_W-1:0];
  assign c_next = sum[DIGIT_W];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial modular add/subtract, LSB digit first, carry kept between digits
module serial_addsub
  import seed_pkg::*;
#(
  parameter int DIGIT_W    = 8,
  parameter int NUM_DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic               cin,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a_in,
  input  logic [DIGIT_W-1:0] b_in,
  output logic [DIGIT_W-1:0] res,
  output logic               res_valid,
  output logic               res_last,
  output logic               cout,
  output logic               busy
);
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_cur;
  logic               mode_q, mode_d, carry_q, carry_d, cout_q, cout_d;
  logic [DIGIT_W-1:0] res_q, res_d, d;
  logic               res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic               accept, last, c_in, c_next;

  digit_addsub #(.DIGIT_W(DIGIT_W)) u_digit (
    .a      (a_in),
    .b      (b_in),
    .c      (c_in),
    .mode   (mode_d),
    .d      (d),
    .c_next (c_next)
  );

  // start overrides everything (including an operation in flight); otherwise RUN consumes valid digits
  always_comb begin
    accept      = start | ((state_q == RUN) & in_valid);
    cnt_cur     = start ? '0 : cnt_q;
    c_in        = start ? cin : carry_q;
    mode_d      = start ? mode : mode_q;
    last        = accept & (cnt_cur == CW'(NUM_DIGITS - 1));
    state_d     = accept ? (last ? IDLE : RUN) : state_q;
    cnt_d       = accept ? cnt_cur + CW'(1) : cnt_q;
    carry_d     = accept ? c_next : carry_q;
    res_d       = accept ? d : res_q;
    res_valid_d = accept;
    res_last_d  = last;
    cout_d      = last ? c_next : cout_q;
  end

  // State, counter, carry and output registers; reset discards any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_ADD;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
    end
  end

  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign res_last  = res_last_q;
  assign cout      = cout_q;
  assign busy      = (state_q == RUN);
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: vector table plus scoreboard for serial_addsub (4-digit and 1-digit builds)
module tb_serial_addsub;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, mode = 1'b0, cin = 1'b0, in_valid = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic [7:0] res;
  logic       res_valid, res_last, cout, busy;
  logic       start1 = 1'b0, mode1 = 1'b0, cin1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic [7:0] res1;
  logic       res_valid1, res_last1, cout1, busy1;

  serial_addsub #(.DIGIT_W(8), .NUM_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .cin(cin), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .res(res), .res_valid(res_valid), .res_last(res_last),
    .cout(cout), .busy(busy)
  );

  serial_addsub #(.DIGIT_W(8), .NUM_DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .cin(cin1), .in_valid(1'b0),
    .a_in(a1), .b_in(b1), .res(res1), .res_valid(res_valid1), .res_last(res_last1),
    .cout(cout1), .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_cout;
    int          stall_at;
    bit          b2b;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] res;
    logic       last;
    logic       cout;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_digit: no res_valid at cycle %0d, required res=%h", sb[0].due, sb[0].res);
        void'(sb.pop_front());
      end
      n_vec++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (res_valid !== 1'b1 || res !== e.res || res_last !== e.last || (e.last && cout !== e.cout)) begin
          n_err++;
          $display("FAIL digit cyc=%0d: got valid=%b res=%h last=%b cout=%b, required valid=1 res=%h last=%b cout=%b",
                   cyc, res_valid, res, res_last, cout, e.res, e.last, e.cout);
        end
      end else if (res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL spurious_valid cyc=%0d: got res_valid=%b res=%h, required res_valid=0", cyc, res_valid, res);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
    end
  endtask

  // Drives one full operation; mode/cin are inverted on non-start digits to prove they are ignored
  task automatic run_op(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k > 0) check("busy_mid_op", {31'b0, busy}, 32'd1);
      start = (k == 0); in_valid = 1'b1;
      mode = (k == 0) ? v.mode : ~v.mode;
      cin = (k == 0) ? v.cin : ~v.cin;
      a_in = v.a[8*k +: 8]; b_in = v.b[8*k +: 8];
      sb.push_back('{cyc + 1, v.exp[8*k +: 8], k == 3, v.exp_cout});
      if (k == v.stall_at) begin
        repeat (2) begin
          @(posedge clk); #1;
          start = 1'b0; in_valid = 1'b0;
          a_in = 8'($urandom); b_in = 8'($urandom); mode = ~mode;
          check("busy_stall", {31'b0, busy}, 32'd1);
        end
      end
    end
  endtask

  task automatic one_digit(input logic m, input logic c, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] er, input logic ec);
    @(posedge clk); #1;
    start1 = 1'b1; mode1 = m; cin1 = c; a1 = a; b1 = b;
    @(posedge clk); @(negedge clk);
    check("nd1_result", {22'b0, res_valid1, res_last1, cout1, busy1, res1}, {22'b0, 1'b1, 1'b1, ec, 1'b0, er});
    #1 start1 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("nd1_after", {29'b0, res_valid1, res_last1, cout1}, {29'b0, 1'b0, 1'b0, ec});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    vec_t rv;
    vt[0] = '{1'b1, 1'b0, 32'h12345678, 32'h9E3779B9, 32'h73FCDCBF, 1'b1, -1, 1'b0};
    vt[1] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, -1, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, -1, 1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h12345678, 32'h9E3779B9, 32'h73FCDCBF, 1'b1,  1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, -1, 1'b1};
    vt[5] = '{1'b1, 1'b1, 32'h00000005, 32'h00000003, 32'h00000001, 1'b0, -1, 1'b0};

    #3;
    check("reset_outputs", {21'b0, res_valid, res_last, cout, busy, res}, 32'd0);
    check("reset_outputs_nd1", {21'b0, res_valid1, res_last1, cout1, busy1, res1}, 32'd0);
    #20 rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 6; i++) begin
      run_op(vt[i]);
      if (!vt[i].b2b) idle(1);
    end

    // in_valid without start in IDLE must be ignored
    repeat (2) begin
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; a_in = 8'hAA; b_in = 8'h55;
    end
    idle(1);
    check("idle_not_busy", {31'b0, busy}, 32'd0);

    // Restart: abort an add after two digits, then a sub completes
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = (k == 0); mode = 1'b0; cin = 1'b0; in_valid = 1'b1;
      a_in = 8'h11; b_in = 8'h22;
      sb.push_back('{cyc + 1, 8'h33, 1'b0, 1'b0});
    end
    run_op(vt[0]);
    idle(1);

    // Random full-word operations against a 33-bit reference
    for (int i = 0; i < 6; i++) begin
      logic [32:0] w;
      rv.mode = 1'($urandom); rv.cin = 1'($urandom);
      rv.a = $urandom; rv.b = $urandom;
      w = rv.mode ? {1'b0, rv.a} - {1'b0, rv.b} - {32'b0, rv.cin}
                  : {1'b0, rv.a} + {1'b0, rv.b} + {32'b0, rv.cin};
      rv.exp = w[31:0]; rv.exp_cout = w[32];
      rv.stall_at = (i == 2) ? 2 : -1; rv.b2b = (i % 2 == 0);
      run_op(rv);
      if (!rv.b2b) idle(1);
    end
    idle(2);

    // Reset in the middle of an operation
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = (k == 0); mode = 1'b1; cin = 1'b0; in_valid = 1'b1;
      a_in = vt[0].a[8*k +: 8]; b_in = vt[0].b[8*k +: 8];
      sb.push_back('{cyc + 1, vt[0].exp[8*k +: 8], 1'b0, 1'b0});
    end
    @(posedge clk); #2;
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    start = 1'b0; in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_reset_outputs", {21'b0, res_valid, res_last, cout, busy, res}, 32'd0);
    idle(2);
    #2 rst_n = 1'b1;
    run_op(vt[0]);
    idle(2);

    // Single-digit build: every start is the last digit
    one_digit(1'b0, 1'b0, 8'hF0, 8'h20, 8'h10, 1'b1);
    one_digit(1'b1, 1'b0, 8'h05, 8'h06, 8'hFF, 1'b1);
    one_digit(1'b0, 1'b1, 8'h01, 8'h01, 8'h03, 1'b0);
    one_digit(1'b1, 1'b1, 8'h09, 8'h03, 8'h05, 1'b0);
    idle(2);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
